// File: rtl/noc_pkg.sv
// Shared NoC constants: flit width and the destination-address field location.
package noc_pkg;
    localparam int NOC_DWIDTH   = 16;
    localparam int NOC_ADDR_W   = 6;
    localparam int NOC_DEST_MSB = NOC_DWIDTH - 1;
    localparam int NOC_DEST_LSB = NOC_DWIDTH - NOC_ADDR_W;
    localparam int NOC_DROP_W   = 8;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO storage and pointers; push/pop legality is enforced by the caller.
module sync_fifo
    import noc_pkg::*;
#(
    parameter int DWIDTH = NOC_DWIDTH,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [DWIDTH-1:0]        wdata_i,
    output logic [DWIDTH-1:0]        rdata_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DWIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    count_q, count_d;

    always_comb begin
        wr_ptr_d = push_i ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop_i  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately left unreset; the pointers alone define validity.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == DEPTH[PTR_W:0]);
    assign empty_o = (count_q == '0);
endmodule

// File: rtl/spine_link_buffer.sv
// Inter-router spine link: FIFO plus registered output stage, link gating and drop counter.
module spine_link_buffer
    import noc_pkg::*;
#(
    parameter int DWIDTH = NOC_DWIDTH,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = NOC_ADDR_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     link_enable,
    input  logic [DWIDTH-1:0]        in_data,
    input  logic                     in_valid,
    output logic [DWIDTH-1:0]        out_data,
    output logic                     out_valid,
    output logic [ADDR_W-1:0]        out_dest_addr,
    input  logic                     out_ready,
    output logic                     fifo_full,
    output logic                     fifo_empty,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic [NOC_DROP_W-1:0]    drop_count
);
    logic [DWIDTH-1:0]     out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;
    logic [NOC_DROP_W-1:0] drop_count_q, drop_count_d;
    logic [DWIDTH-1:0]     head_data;
    logic                  out_free, push, pop, drop;

    sync_fifo #(
        .DWIDTH (DWIDTH),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (in_data),
        .rdata_o (head_data),
        .count_o (occupancy),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // A full FIFO still accepts a flit when the head leaves in the same cycle.
    always_comb begin
        out_free     = !out_valid_q || (out_ready && link_enable);
        pop          = !fifo_empty && link_enable && out_free;
        push         = in_valid && (!fifo_full || pop);
        drop         = in_valid && fifo_full && !pop;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        drop_count_d = drop_count_q;
        if (pop) begin
            out_valid_d = 1'b1;
            out_data_d  = head_data;
        end else if (out_free) begin
            out_valid_d = 1'b0;
        end
        if (drop && (drop_count_q != '1)) drop_count_d = drop_count_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            drop_count_q <= '0;
        end else begin
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign out_data      = out_data_q;
    assign out_valid     = out_valid_q;
    assign out_dest_addr = out_data_q[DWIDTH-1:DWIDTH-ADDR_W];
    assign drop_count    = drop_count_q;
endmodule

// File: tb/tb_spine_link_buffer.sv
// Directed bench for spine_link_buffer with a queue scoreboard checked on every output transfer.
module tb_spine_link_buffer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        link_enable = 1'b1;
    logic [15:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic [15:0] out_data;
    logic        out_valid;
    logic [5:0]  out_dest_addr;
    logic        out_ready = 1'b1;
    logic        fifo_full;
    logic        fifo_empty;
    logic [3:0]  occupancy;
    logic [7:0]  drop_count;

    int checks = 0;
    int failures = 0;
    logic [15:0] exp_q [$];

    spine_link_buffer #(.DWIDTH(16), .DEPTH(8), .ADDR_W(6)) dut (
        .clk           (clk),
        .reset         (reset),
        .link_enable   (link_enable),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_dest_addr (out_dest_addr),
        .out_ready     (out_ready),
        .fifo_full     (fifo_full),
        .fifo_empty    (fifo_empty),
        .occupancy     (occupancy),
        .drop_count    (drop_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_data"}, 32'(out_data), 32'd0);
        check({tag, "_occupancy"}, 32'(occupancy), 32'd0);
        check({tag, "_empty"}, 32'(fifo_empty), 32'd1);
        check({tag, "_full"}, 32'(fifo_full), 32'd0);
        check({tag, "_drops"}, 32'(drop_count), 32'd0);
    endtask

    // Scoreboard monitor: every accepted output flit must be the oldest expected one.
    always @(negedge clk) begin
        logic [15:0] e;
        if (!reset && out_valid && out_ready && link_enable) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected: got 0x%0h expected no flit", out_data);
            end else begin
                e = exp_q.pop_front();
                check("sb_data", 32'(out_data), 32'(e));
                check("sb_dest", 32'(out_dest_addr), 32'(e[15:10]));
            end
        end
    end

    initial begin
        cycle();
        cycle();
        check_reset_state("rst");
        reset = 1'b0;

        // Single flit latency.
        in_valid = 1'b1;
        in_data  = 16'hA5C3;
        exp_q.push_back(16'hA5C3);
        cycle();
        in_valid = 1'b0;
        check("lat_n_valid", 32'(out_valid), 32'd0);
        cycle();
        check("lat_n1_valid", 32'(out_valid), 32'd1);
        check("lat_n1_data", 32'(out_data), 32'hA5C3);
        check("lat_n1_dest", 32'(out_dest_addr), 32'h29);
        cycle();
        check("lat_n2_valid", 32'(out_valid), 32'd0);

        // Fill against a stalled output; the tenth flit is lost.
        out_ready = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            in_valid = 1'b1;
            in_data  = 16'(i);
            if (i <= 9) exp_q.push_back(16'(i));
            cycle();
        end
        in_valid = 1'b0;
        check("fill_out_valid", 32'(out_valid), 32'd1);
        check("fill_out_data", 32'(out_data), 32'h0001);
        check("fill_full", 32'(fifo_full), 32'd1);
        check("fill_occupancy", 32'(occupancy), 32'd8);
        check("fill_drops", 32'(drop_count), 32'd1);

        // Full FIFO streaming: push and pop every cycle.
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            in_data  = 16'h0100 + 16'(i);
            exp_q.push_back(16'h0100 + 16'(i));
            cycle();
            check("stream_occupancy", 32'(occupancy), 32'd8);
            check("stream_drops", 32'(drop_count), 32'd1);
        end
        in_valid = 1'b0;
        for (int i = 0; i < 12; i++) cycle();
        check("drain_empty", 32'(fifo_empty), 32'd1);
        check("drain_out_valid", 32'(out_valid), 32'd0);
        check("drain_sb_left", 32'(exp_q.size()), 32'd0);

        // Link disabled: pushes accepted, nothing leaves.
        link_enable = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            in_valid = 1'b1;
            in_data  = 16'h0200 + 16'(i);
            exp_q.push_back(16'h0200 + 16'(i));
            cycle();
        end
        in_valid = 1'b0;
        cycle();
        check("dis_out_valid", 32'(out_valid), 32'd0);
        check("dis_occupancy", 32'(occupancy), 32'd3);
        link_enable = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            cycle();
            check("en_burst_valid", 32'(out_valid), 32'd1);
            check("en_burst_data", 32'(out_data), 32'h0200 + 32'(i));
        end
        cycle();
        check("en_burst_end", 32'(out_valid), 32'd0);

        // Asynchronous reset mid-cycle with five flits buffered.
        out_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            in_valid = 1'b1;
            in_data  = 16'h0300 + 16'(i);
            cycle();
        end
        in_valid = 1'b0;
        check("pre_rst_occupancy", 32'(occupancy), 32'd5);
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check_reset_state("async_rst");
        cycle();
        reset = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle();
            check("post_rst_no_stale", 32'(out_valid), 32'd0);
        end

        // Drop counter saturation.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 9 + 254; i++) begin
            in_data = 16'(i);
            cycle();
        end
        check("drops_254", 32'(drop_count), 32'd254);
        cycle();
        check("drops_255", 32'(drop_count), 32'd255);
        for (int i = 0; i < 45; i++) cycle();
        check("drops_sat", 32'(drop_count), 32'd255);
        in_valid = 1'b0;
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        cycle();
        check("final_sb_left", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
